text_scan_sequencer: RTL and testbench
======================================

// Module: text_scan_sequencer
// PURPOSE
//  Raster sequencer for the character-cell text display path. Walks the screen cell by cell and glyph
//  line by glyph line, reading ASCII codes from a single-port text RAM. Drives ascii/pixel_count/
//  line_count into the glyph-to-pixel datapath. Shares the text RAM port with a host writer
//  (scan reads have priority).
// PARAMETERS
//  COLS    80  character columns per text row
//  ROWS    30  text rows per frame
//  ADDR_W  12  text RAM address width; COLS*ROWS <= 2**ADDR_W
// PORTS
//  clk         in   1       single system clock, all logic rising-edge
//  rst_n       in   1       synchronous, active-low reset
//  enable      in   1       sequencer enable
//  frame_start in   1       1-cycle pulse: begin frame at cell (0,0)
//  pix_req     in   1       downstream accepts one pixel this cycle (active video)
//  ram_addr    out  ADDR_W  text RAM address (read or write)
//  ram_rd_en   out  1       text RAM read strobe; data valid on ram_rdata next cycle
//  ram_we      out  1       text RAM write strobe
//  ram_wdata   out  8       text RAM write data
//  ram_rdata   in   8       text RAM read data, 1-cycle latency
//  wr_req      in   1       host write request, held until wr_ack
//  wr_addr     in   ADDR_W  host write address
//  wr_data     in   8       host write ASCII
//  wr_ack      out  1       1-cycle pulse in the cycle ram_we is asserted for the host
//  ascii       out  8       character code to the glyph path
//  pixel_count out  3       pixel column within glyph, 0..7
//  line_count  out  3       glyph line, 0..7
//  glyph_valid out  1       ascii/pixel_count/line_count are valid this cycle
//  frame_done  out  1       1-cycle pulse after last pixel of cell (COLS-1,ROWS-1), line 7
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; col/row/row_base/counters cleared.
//  FSM: IDLE -(enable & frame_start)-> FETCH -> WAIT -> EMIT. EMIT -(frame end)-> IDLE.
//   FETCH: ram_rd_en=1, ram_addr=row_base+col. WAIT: ascii<=ram_rdata.
//   EMIT: glyph_valid=1; on pix_req, pixel_count++. pix_req=0 freezes every counter and output.
//  Prefetch: in EMIT, when pixel_count==6 & pix_req, issue read of next cell address. At
//   pixel_count==7 & pix_req, ascii<=ram_rdata. Gapless output across cells; 1 read per 8 pixels.
//  Advance order at pixel 7 & pix_req: col++. At col COLS-1: col<=0, line_count++.
//   At line 7: row++, row_base+=COLS (adder only, no multiply). At row ROWS-1: frame_done pulse, ->IDLE.
//  Output latency: first glyph_valid 2 cycles after frame_start; outputs registered.
//  Arbitration: a host write is granted in any cycle with no scan read
//   (IDLE, WAIT, EMIT except the prefetch cycle).
//   Grant: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1. Scan read wins a collision;
//   the host waits one cycle. Never ram_we & ram_rd_en in the same cycle.
//  frame_start while not IDLE: abort, counters cleared, FETCH next cycle (restart at address 0).
//  enable=0: IDLE next cycle, glyph_valid=0; host writes still serviced.
//  wr_addr >= COLS*ROWS: still written, no check. Reset mid-frame: full reset; pending write dropped.
// CONFIGURATION
//  TEXT_CURSOR_EN defined: extra inputs cursor_col[6:0], cursor_row[4:0]; output cursor_on.
//   6-bit frame counter increments on frame_done. cursor_on=1 when
//   (col,row)==cursor & line_count==7 & frame_cnt[5]; registered and aligned with glyph_valid.
//  Not defined: no cursor ports, no frame counter; behaviour otherwise identical.
// STRUCTURE
//  Shared package text_disp_pkg: GLYPH_W=8, GLYPH_H=8, FSM state enum
//   (S_IDLE,S_FETCH,S_WAIT,S_EMIT), default COLS/ROWS.
//  One sub-module: text_ram_arb (scan-read vs host-write mux, wr_ack generation).
// TESTING
//  1 Reset, enable=1, frame_start, pix_req=1, COLS=4 ROWS=2, RAM[i]=0x41+i -> glyph_valid at cycle 2;
//    ascii 0x41x8,0x42x8,...; 8 lines per row; frame_done after 4*2*64 pixels.
//  2 Toggle pix_req 50% mid-cell -> pixel_count/ascii hold while low; sequence identical to test 1.
//  3 Host wr_req held continuously during EMIT -> wr_ack never in a prefetch cycle;
//    new RAM data seen on the next scan of that cell.
//  4 frame_start at row 1 line 3 -> next FETCH addr 0, line_count=0, no frame_done for aborted frame.
//  5 enable=0 mid-cell -> glyph_valid=0 next cycle; a host write during IDLE acks in 1 cycle.
//  6 TEXT_CURSOR_EN, cursor=(2,1) -> cursor_on only on line 7 of cell (2,1), per 32-frame blink phase.

Source files
------------

// File: rtl/text_disp_pkg.sv
// Shared definitions for the character-cell text display path: glyph geometry,
// sequencer state encoding and counter-width helper.
package text_disp_pkg;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 8;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/text_ram_arb.sv
// Single-port text RAM mux: scan reads own the port when requested; host writes
// are granted (and acknowledged) in every other cycle.
module text_ram_arb #(
  parameter int ADDR_W = 12
) (
  input  logic              active,
  input  logic              scan_rd,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  output logic              wr_ack
);

  logic grant;

  // Held in reset via active, so a write pending across reset is dropped.
  assign ram_rd_en = active & scan_rd;
  assign grant     = active & wr_req & ~scan_rd;
  assign ram_we    = grant;
  assign wr_ack    = grant;
  assign ram_wdata = grant ? wr_data : 8'h00;

  always_comb begin
    ram_addr = '0;
    if (ram_rd_en)
      ram_addr = scan_addr;
    else if (grant)
      ram_addr = wr_addr;
  end

endmodule

// File: rtl/text_scan_sequencer.sv
// Raster sequencer for the text display: walks cells and glyph lines, prefetching ASCII
// one cell ahead. Optional blinking cursor overlay when TEXT_CURSOR_EN is defined.
module text_scan_sequencer
  import text_disp_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic              cursor_on,
`endif
  output logic [7:0]        ascii,
  output logic [2:0]        pixel_count,
  output logic [2:0]        line_count,
  output logic              glyph_valid,
  output logic              frame_done
);

  localparam int COL_W = cnt_w(COLS);
  localparam int ROW_W = cnt_w(ROWS);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [2:0]        PIX_LAST = 3'(GLYPH_W - 1);
  localparam logic [2:0]        LIN_LAST = 3'(GLYPH_H - 1);

  state_t            state;
  logic [COL_W-1:0]  col, col_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [2:0]        line_n;
  logic              step, cell_end, last_cell, scan_rd;
  logic [ADDR_W-1:0] scan_addr;

  assign step      = (state == S_EMIT) & enable & ~frame_start & pix_req;
  assign cell_end  = step & (pixel_count == PIX_LAST);
  assign last_cell = (col == COL_LAST) & (line_count == LIN_LAST) & (row == ROW_LAST);

  // Position of the cell that follows the one on screen; row_base steps by COLS.
  always_comb begin
    col_n      = col + 1'b1;
    row_n      = row;
    row_base_n = row_base;
    line_n     = line_count;
    if (col == COL_LAST) begin
      col_n  = '0;
      line_n = line_count + 3'd1;
      if (line_count == LIN_LAST) begin
        row_n      = row + 1'b1;
        row_base_n = row_base + COLS_A;
      end
    end
  end

  // Read one pixel early so the next code sits on ram_rdata when the cell ends.
  assign scan_rd   = (state == S_FETCH) | (step & (pixel_count == 3'd6) & ~last_cell);
  assign scan_addr = (state == S_FETCH) ? row_base + ADDR_W'(col)
                                        : row_base_n + ADDR_W'(col_n);

  text_ram_arb #(.ADDR_W(ADDR_W)) u_arb (
    .active    (rst_n),
    .scan_rd   (scan_rd),
    .scan_addr (scan_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .wr_ack    (wr_ack)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      row_base    <= '0;
      ascii       <= '0;
      pixel_count <= '0;
      line_count  <= '0;
      glyph_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state       <= S_IDLE;
        glyph_valid <= 1'b0;
      end else if (frame_start) begin
        state       <= S_FETCH;
        glyph_valid <= 1'b0;
        col         <= '0;
        row         <= '0;
        row_base    <= '0;
        pixel_count <= '0;
        line_count  <= '0;
      end else begin
        case (state)
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            ascii       <= ram_rdata;
            glyph_valid <= 1'b1;
            state       <= S_EMIT;
          end
          S_EMIT: begin
            if (step)
              pixel_count <= pixel_count + 3'd1;
            if (cell_end) begin
              if (last_cell) begin
                state       <= S_IDLE;
                glyph_valid <= 1'b0;
                frame_done  <= 1'b1;
                col         <= '0;
                row         <= '0;
                row_base    <= '0;
                line_count  <= '0;
              end else begin
                ascii      <= ram_rdata;
                col        <= col_n;
                row        <= row_n;
                row_base   <= row_base_n;
                line_count <= line_n;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TEXT_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       hit_next;

  // Evaluated on the position being loaded so cursor_on changes with ascii.
  assign hit_next = (32'(col_n) == 32'(cursor_col)) & (32'(row_n) == 32'(cursor_row)) &
                    (line_n == LIN_LAST) & frame_cnt[5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      cursor_on <= 1'b0;
    end else begin
      if (cell_end & last_cell)
        frame_cnt <= frame_cnt + 6'd1;
      if (!enable || frame_start || state != S_EMIT)
        cursor_on <= 1'b0;
      else if (cell_end)
        cursor_on <= ~last_cell & hit_next;
    end
  end
`endif

endmodule

// File: tb/tb_text_scan_sequencer.sv
// Directed bench for text_scan_sequencer with a registered-read RAM model and a pixel scoreboard.
`timescale 1ns/1ps
module tb_text_scan_sequencer;
  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int ADDR_W = 12;

  typedef struct packed {
    logic [7:0] ascii;
    logic [2:0] pix;
    logic [2:0] line;
    logic       cur;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, frame_start = 1'b0, pix_req = 1'b0, wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, ram_addr;
  logic [7:0] wr_data = '0, ram_wdata, ram_rdata = '0, ascii;
  logic ram_rd_en, ram_we, wr_ack, glyph_valid, frame_done;
  logic [2:0] pixel_count, line_count;
`ifdef TEXT_CURSOR_EN
  logic [6:0] cursor_col = 7'd2;
  logic [4:0] cursor_row = 5'd1;
  logic cursor_on;
`endif

  logic pl_we = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] shadow [0:COLS*ROWS-1];
  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0, n_err = 0, n_rd = 0, n_ack = 0, n_done = 0, frames_model = 0;

  always #5 clk = ~clk;

  text_scan_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start), .pix_req(pix_req),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack),
`ifdef TEXT_CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on),
`endif
    .ascii(ascii), .pixel_count(pixel_count), .line_count(line_count),
    .glyph_valid(glyph_valid), .frame_done(frame_done)
  );

  // Text RAM: registered read, rdata holds between reads.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < 8; l++)
        for (int c = 0; c < COLS; c++)
          for (int p = 0; p < 8; p++) begin
            e.ascii = shadow[r*COLS + c];
            e.pix   = 3'(p);
            e.line  = 3'(l);
            e.cur   = (c == 2) && (r == 1) && (l == 7) && frames_model[5];
            sb.push_back(e);
          end
  endtask

  // Monitor: consumes one scoreboard entry per accepted pixel, checks port arbitration.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_rd_en) n_rd++;
      if (frame_done) n_done++;
      if (wr_ack) begin
        n_ack++;
        chk("ack_grant", 32'({ram_rd_en, ram_we, ram_addr}), 32'({1'b0, 1'b1, wr_addr}));
      end
      if (wr_req && ram_rd_en)
        chk("read_wins", 32'({wr_ack, ram_we}), 32'd0);
      if (glyph_valid && pix_req) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("pixel", 32'({ascii, pixel_count, line_count}),
              32'({mon_e.ascii, mon_e.pix, mon_e.line}));
`ifdef TEXT_CURSOR_EN
          chk("cursor", 32'(cursor_on), 32'(mon_e.cur));
`endif
        end
      end
    end
  end

  // Entered in the FETCH cycle (frame_start just sampled); runs the frame to frame_done.
  task automatic wait_frame(input bit rnd, input string tag);
    int cyc, d0, r0;
    d0 = n_done;
    r0 = n_rd;
    cyc = 1;
    chk({tag, "_fetch"}, 32'({ram_rd_en, ram_addr, line_count, pixel_count, glyph_valid}),
        32'({1'b1, 12'd0, 3'd0, 3'd0, 1'b0}));
    while (!frame_done && cyc < 4000) begin
      if (rnd) pix_req = 1'($urandom_range(0, 1));
      tick(1);
      cyc++;
      if (cyc == 2) chk({tag, "_lat2"}, 32'(glyph_valid), 32'd0);
      if (cyc == 3) chk({tag, "_lat3"}, 32'(glyph_valid), 32'd1);
    end
    chk({tag, "_done"}, 32'(frame_done), 32'd1);
    if (!rnd) chk({tag, "_cycles"}, 32'(cyc), 32'd515);
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    pix_req = 1'b1;
    tick(1);
    chk({tag, "_pulse"}, 32'({frame_done, glyph_valid}), 32'd0);
    chk({tag, "_ndone"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_reads"}, 32'(n_rd - r0), 32'(COLS*ROWS*8));
    frames_model++;
  endtask

  task automatic run_frame(input bit rnd, input string tag);
    push_frame();
    frame_start = 1'b1;
    pix_req = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_frame(rnd, tag);
  endtask

  initial begin
    int a0;
    // Reset with RAM preload 0x41+i
    rst_n = 1'b0;
    for (int i = 0; i < COLS*ROWS; i++) begin
      shadow[i] = 8'(8'h41 + i);
      pl_we = 1'b1; pl_addr = ADDR_W'(i); pl_data = 8'(8'h41 + i);
      tick(1);
    end
    pl_we = 1'b0;
    tick(2);
    chk("rst_glyph", 32'({ascii, pixel_count, line_count, glyph_valid, frame_done}), 32'd0);
    chk("rst_ram", 32'({ram_rd_en, ram_we, wr_ack}), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1);

    // Steady pixel stream
    run_frame(1'b0, "steady");

    // Throttled pixel stream
    run_frame(1'b1, "throttle");

    // Host write held through a frame; lands before cell 5 is scanned
    a0 = n_ack;
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h7A;
    shadow[5] = 8'h7A;
    run_frame(1'b0, "hostwr");
    wr_req = 1'b0;
    chk("hostwr_acks", 32'(n_ack - a0 > 400), 32'd1);

    // Abort at row 1, line 3, pixel 5
    push_frame();
    frame_start = 1'b1; pix_req = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(359);
    chk("abort_pos", 32'({line_count, pixel_count}), 32'({3'd3, 3'd5}));
    frame_start = 1'b1;
    @(negedge clk); #1;
    sb.delete();
    push_frame();
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_frame(1'b0, "restart");

    // Disable mid-cell, then a host write while idle
    push_frame();
    frame_start = 1'b1; pix_req = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(100);
    enable = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    @(posedge clk); #1;
    chk("disable_idle", 32'({glyph_valid, ram_rd_en}), 32'd0);
    wr_req = 1'b1; wr_addr = 12'd2; wr_data = 8'h55;
    #1;
    chk("idle_ack", 32'({wr_ack, ram_we, ram_wdata}), 32'({1'b1, 1'b1, 8'h55}));
    tick(1);
    wr_req = 1'b0;
    chk("idle_wr_mem", 32'(mem[2]), 32'h55);
    shadow[2] = 8'h55;
    enable = 1'b1;
    tick(1);

    // Reset mid-frame with a write pending
    push_frame();
    frame_start = 1'b1; pix_req = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(200);
    rst_n = 1'b0;
    wr_req = 1'b1; wr_addr = 12'd6; wr_data = 8'h66;
    #1;
    chk("rst_no_ack", 32'({wr_ack, ram_we}), 32'd0);
    @(negedge clk); #1;
    sb.delete();
    tick(1);
    chk("rst_mid", 32'({ascii, pixel_count, line_count, glyph_valid, frame_done, ram_rd_en}), 32'd0);
    tick(1);
    wr_req = 1'b0;
    rst_n = 1'b1;
    chk("rst_drop_wr", 32'(mem[6]), 32'h47);
    frames_model = 0;
    tick(1);

    // Updated cells appear on the next scan
    run_frame(1'b0, "final");

`ifdef TEXT_CURSOR_EN
    // Cursor blink phase flips after 32 frames
    for (int f = 0; f < 33; f++) run_frame(1'b0, "cursor");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
